// File: rtl/switch_pick_conditioner.sv
// Tile switch front end: synchronises and debounces SW, queues one pick per
// debounced rising flip of an unmatched tile, and hands picks out lowest index first.
module switch_pick_conditioner #(
  parameter int unsigned NUM_SW          = 10,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic [NUM_SW-1:0] SW,
  input  logic [NUM_SW-1:0] matched_mask,
  input  logic              pick_ready,
  output logic              pick_valid,
  output logic [3:0]        pick_idx,
  output logic [NUM_SW-1:0] pick_onehot,
  output logic [NUM_SW-1:0] sw_stable
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {IDLE, PRESENT} state_t;

  state_t            state;
  logic [NUM_SW-1:0] sw_s1;
  logic [NUM_SW-1:0] sw_s2;
  logic [NUM_SW-1:0] stable_d;
  logic [NUM_SW-1:0] pending;
  logic [CNT_W-1:0]  cnt [NUM_SW];

  logic [NUM_SW-1:0] rise;
  logic [NUM_SW-1:0] fall;
  logic [NUM_SW-1:0] presented;
  logic [NUM_SW-1:0] withdraw;
  logic [NUM_SW-1:0] avail;
  logic [NUM_SW-1:0] pending_n;
  logic              lo_any;
  logic [3:0]        lo_idx;
  logic [NUM_SW-1:0] lo_hot;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sw_s1     <= '0;
      sw_s2     <= '0;
      sw_stable <= '0;
      stable_d  <= '0;
      for (int unsigned i = 0; i < NUM_SW; i++) cnt[i] <= '0;
    end else begin
      sw_s1    <= SW;
      sw_s2    <= sw_s1;
      stable_d <= sw_stable;
      // Count consecutive samples disagreeing with the accepted level; flip on the Nth.
      for (int unsigned i = 0; i < NUM_SW; i++) begin
        if (sw_s2[i] == sw_stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          sw_stable[i] <= ~sw_stable[i];
          cnt[i]       <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    rise      = sw_stable & ~stable_d;
    fall      = ~sw_stable & stable_d;
    presented = (state == PRESENT) ? pick_onehot : '0;
    withdraw  = (fall | matched_mask) & ~presented;
    avail     = pending & ~withdraw;
    pending_n = (pending | (rise & ~matched_mask)) & ~withdraw;
    if (state == PRESENT && pick_ready) pending_n = pending_n & ~pick_onehot;
  end

  // Scan from the top so the last hit, i.e. the lowest index, wins.
  always_comb begin
    lo_any = 1'b0;
    lo_idx = '0;
    lo_hot = '0;
    for (int unsigned i = 0; i < NUM_SW; i++) begin
      if (avail[NUM_SW-1-i]) begin
        lo_any = 1'b1;
        lo_idx = 4'(NUM_SW - 1 - i);
        lo_hot = '0;
        lo_hot[NUM_SW-1-i] = 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state       <= IDLE;
      pick_valid  <= 1'b0;
      pick_idx    <= '0;
      pick_onehot <= '0;
      pending     <= '0;
    end else begin
      pending <= pending_n;
      case (state)
        IDLE: begin
          if (lo_any) begin
            pick_idx    <= lo_idx;
            pick_onehot <= lo_hot;
            pick_valid  <= 1'b1;
            state       <= PRESENT;
          end
        end
        PRESENT: begin
          if (pick_ready) begin
            pick_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          pick_valid <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_switch_pick_conditioner.sv
// Self-checking bench: directed scenarios with literal expectations, then random
// switch/mask/ready traffic checked every cycle against a behavioural model.
module tb_switch_pick_conditioner;

  localparam int NSW = 10;
  localparam int DB  = 4;

  logic           CLOCK_50 = 1'b0;
  logic           reset;
  logic [NSW-1:0] SW;
  logic [NSW-1:0] matched_mask;
  logic           pick_ready;
  logic           pick_valid;
  logic [3:0]     pick_idx;
  logic [NSW-1:0] pick_onehot;
  logic [NSW-1:0] sw_stable;

  switch_pick_conditioner #(
    .NUM_SW(NSW),
    .DEBOUNCE_CYCLES(DB),
    .CNT_W(3)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .reset(reset),
    .SW(SW),
    .matched_mask(matched_mask),
    .pick_ready(pick_ready),
    .pick_valid(pick_valid),
    .pick_idx(pick_idx),
    .pick_onehot(pick_onehot),
    .sw_stable(sw_stable)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int n_vec = 0;
  int n_err = 0;

  // Model state: delayed raw samples, run lengths, accepted levels, pick queue.
  logic [NSW-1:0] m_s1 = '0, m_s2 = '0, m_stable = '0, m_prev = '0, m_pend = '0;
  logic [NSW-1:0] m_onehot = '0;
  logic [3:0]     m_idx = '0;
  logic           m_valid = 1'b0;
  int             m_run [NSW];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_edge();
    logic [NSW-1:0] n_stable, rise, fall, pres, wd, avail, n_pend;
    if (reset) begin
      m_s1 = '0; m_s2 = '0; m_stable = '0; m_prev = '0; m_pend = '0;
      m_onehot = '0; m_idx = '0; m_valid = 1'b0;
      for (int i = 0; i < NSW; i++) m_run[i] = 0;
      return;
    end
    rise = m_stable & ~m_prev;
    fall = ~m_stable & m_prev;
    n_stable = m_stable;
    for (int i = 0; i < NSW; i++) begin
      if (m_s2[i] != m_stable[i]) begin
        m_run[i] = m_run[i] + 1;
        if (m_run[i] == DB) begin
          n_stable[i] = ~m_stable[i];
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    pres   = m_valid ? m_onehot : '0;
    wd     = (fall | matched_mask) & ~pres;
    avail  = m_pend & ~wd;
    n_pend = (m_pend | (rise & ~matched_mask)) & ~wd;
    if (m_valid) begin
      if (pick_ready) begin
        n_pend  = n_pend & ~m_onehot;
        m_valid = 1'b0;
      end
    end else if (avail != '0) begin
      for (int i = NSW - 1; i >= 0; i--) begin
        if (avail[i]) begin
          m_idx = 4'(i);
          m_onehot = NSW'(1) << i;
        end
      end
      m_valid = 1'b1;
    end
    m_prev   = m_stable;
    m_stable = n_stable;
    m_s2     = m_s1;
    m_s1     = SW;
    m_pend   = n_pend;
  endtask

  task automatic step();
    @(posedge CLOCK_50);
    model_edge();
    #1;
    check("valid", 16'(pick_valid), 16'(m_valid));
    check("sw_stable", 16'(sw_stable), 16'(m_stable));
    if (m_valid) begin
      check("idx", 16'(pick_idx), 16'(m_idx));
      check("onehot", 16'(pick_onehot), 16'(m_onehot));
    end
  endtask

  task automatic settle(input int n);
    repeat (n) step();
  endtask

  initial begin
    reset = 1'b1; SW = '0; matched_mask = '0; pick_ready = 1'b0;
    for (int i = 0; i < NSW; i++) m_run[i] = 0;

    // 1: reset with all switches high; mask keeps the rising levels from queueing picks
    SW = 10'h3FF; matched_mask = 10'h3FF;
    step(); step();
    check("t1_rst_valid", 16'(pick_valid), 16'h0);
    check("t1_rst_idx", 16'(pick_idx), 16'h0);
    check("t1_rst_onehot", 16'(pick_onehot), 16'h0);
    check("t1_rst_stable", 16'(sw_stable), 16'h0);
    reset = 1'b0;
    settle(5);
    check("t1_stable_e5", 16'(sw_stable), 16'h0);
    step();
    check("t1_stable_e6", 16'(sw_stable), 16'h3FF);
    SW = '0; settle(8); matched_mask = '0; step();

    // 2: single pick held while not ready
    SW = 10'h008;
    settle(7);
    check("t2_valid_e7", 16'(pick_valid), 16'h0);
    step();
    check("t2_valid_e8", 16'(pick_valid), 16'h1);
    check("t2_idx", 16'(pick_idx), 16'h3);
    check("t2_onehot", 16'(pick_onehot), 16'h008);
    for (int k = 0; k < 5; k++) begin
      step();
      check("t2_hold", 16'({pick_valid, pick_idx}), 16'h13);
    end
    pick_ready = 1'b1; step();
    check("t2_accept", 16'(pick_valid), 16'h0);
    pick_ready = 1'b0; SW = '0; settle(8);

    // 3: short glitch is filtered
    SW = 10'h020; settle(3); SW = '0;
    for (int k = 0; k < 10; k++) begin
      step();
      check("t3_glitch", 16'({pick_valid, sw_stable[5]}), 16'h0);
    end

    // 4: simultaneous rises, lowest first with one idle cycle between
    pick_ready = 1'b1; SW = 10'h084;
    settle(7);
    step(); check("t4_first", 16'({pick_valid, pick_idx}), 16'h12);
    step(); check("t4_gap", 16'(pick_valid), 16'h0);
    step(); check("t4_second", 16'({pick_valid, pick_idx}), 16'h17);
    step(); check("t4_done", 16'(pick_valid), 16'h0);
    SW = '0; pick_ready = 1'b0; settle(8);

    // 5: matched tile debounces but never picks
    matched_mask = 10'h010; SW = 10'h010;
    settle(5);
    check("t5_stable_e5", 16'(sw_stable[4]), 16'h0);
    step();
    check("t5_stable_e6", 16'(sw_stable[4]), 16'h1);
    for (int k = 0; k < 4; k++) begin
      step();
      check("t5_nopick", 16'(pick_valid), 16'h0);
    end
    SW = '0; settle(8); matched_mask = '0; step();

    // 6: reset mid-presentation, switch held high
    SW = 10'h002;
    settle(8);
    check("t6_present", 16'({pick_valid, pick_idx}), 16'h11);
    reset = 1'b1; step();
    check("t6_rst", 16'({pick_valid, pick_idx, pick_onehot}), 16'h0);
    reset = 1'b0;
    settle(7);
    check("t6_e7", 16'(pick_valid), 16'h0);
    step();
    check("t6_e8", 16'({pick_valid, pick_idx}), 16'h11);
    pick_ready = 1'b1; step();
    check("t6_accept", 16'(pick_valid), 16'h0);
    pick_ready = 1'b0; SW = '0; settle(8);

    // random traffic: bouncing switches, mask updates, ready jitter, rare resets
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < NSW; i++)
        if ($urandom_range(0, 15) == 0) SW[i] = ~SW[i];
      if ($urandom_range(0, 63) == 0) matched_mask = NSW'($urandom & $urandom);
      pick_ready = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 499) == 0);
      step();
    end
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
